// File: rtl/fifo_merge_pkg.sv
// Shared defaults, tag-width helper and the default word type for the fifo_in merger.
package fifo_merge_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned CNT_W_DEF  = 16;
   localparam int unsigned SRC_W_DEF  = 1;

   // Tag width never collapses to zero, even for a single-port build.
   function automatic int unsigned src_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [SRC_W_DEF-1:0]  src;
   } merge_word_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready register slice (main + skid); in_rdy never looks at out_rdy.
module fifo_skid_buf
   import fifo_merge_pkg::*;
#(
   parameter type word_t = merge_word_t
) (
   input  logic  clk,
   input  logic  rst,
   input  word_t in_word,
   input  logic  in_vld,
   output logic  in_rdy,
   output word_t out_word,
   output logic  out_vld,
   input  logic  out_rdy
);

   word_t main_q, main_d;
   word_t skid_q, skid_d;
   logic  main_vld_q, main_vld_d;
   logic  skid_vld_q, skid_vld_d;
   logic  in_fire;

   assign in_rdy   = !skid_vld_q;
   assign in_fire  = in_vld && in_rdy;
   assign out_word = main_q;
   assign out_vld  = main_vld_q;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!main_vld_q || out_rdy) begin
         // Main is free this edge: the older skid word has priority over new input.
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = in_fire;
            if (in_fire) begin
               main_d = in_word;
            end
         end
      end else if (in_fire) begin
         skid_d     = in_word;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         main_vld_q <= main_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

endmodule

// File: rtl/fifo_in_rr_merge.sv
// Round-robin merge of N_IN producer streams into one registered, source-tagged stream.
module fifo_in_rr_merge
   import fifo_merge_pkg::*;
#(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned SRC_W  = src_width(N_IN),
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_IN-1:0][DATA_W-1:0]  data_in,
   input  logic [N_IN-1:0]              data_in_vld,
   output logic [N_IN-1:0]              data_in_rdy,
   output logic [DATA_W-1:0]            data_out,
   output logic [SRC_W-1:0]             data_out_src,
   output logic                         data_out_vld,
   input  logic                         data_out_rdy,
   output logic [CNT_W-1:0]             xfer_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SRC_W-1:0]  src;
   } word_t;

   logic [SRC_W-1:0] ptr_q, ptr_d;
   logic [SRC_W-1:0] cand;
   logic [SRC_W-1:0] gnt_idx;
   logic             gnt_found;
   logic             accept;
   logic             in_vld;
   logic             in_fire;
   logic             out_fire;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   word_t            in_word;
   word_t            out_word;

   // Modular add for port indices; a < N_IN and b <= N_IN so one subtraction suffices.
   function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a,
                                                input int unsigned b);
      int unsigned s;
      s = 32'(a) + b;
      if (s >= N_IN) begin
         s = s - N_IN;
      end
      return SRC_W'(s);
   endfunction

   always_comb begin
      cand      = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         cand = wrap_add(ptr_q, i);
         if (!gnt_found && data_in_vld[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Reset masks the request so no port sees ready while rst is high.
   assign in_vld  = gnt_found && !rst;
   assign in_fire = in_vld && accept;

   always_comb begin
      data_in_rdy = '0;
      if (in_vld) begin
         data_in_rdy[gnt_idx] = accept;
      end
   end

   always_comb begin
      in_word.data = data_in[gnt_idx];
      in_word.src  = gnt_idx;
   end

   fifo_skid_buf #(
      .word_t(word_t)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .in_word (in_word),
      .in_vld  (in_vld),
      .in_rdy  (accept),
      .out_word(out_word),
      .out_vld (data_out_vld),
      .out_rdy (data_out_rdy)
   );

   assign data_out     = out_word.data;
   assign data_out_src = out_word.src;
   assign out_fire     = data_out_vld && data_out_rdy;
   assign xfer_cnt     = cnt_q;

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (in_fire) begin
         ptr_d = wrap_add(gnt_idx, 1);
      end
      if (out_fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_in_rr_merge.sv
// Bench for fifo_in_rr_merge: a 2-port and a 3-port instance checked against a queue model.
module tb_fifo_in_rr_merge;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] data;
   } mw_t;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  src;
      logic [31:0] data;
   } logw_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0]        vld_drv [2];
   logic [2:0][31:0]  dat_drv [2];
   logic              ordy    [2];

   logic [1:0]  rdy0;
   logic [31:0] dout0;
   logic        src0;
   logic        ov0;
   logic [15:0] cnt0;
   logic [2:0]  rdy1;
   logic [31:0] dout1;
   logic [1:0]  src1;
   logic        ov1;
   logic [15:0] cnt1;

   int n_chk  = 0;
   int n_pass = 0;
   int unsigned cycle = 0;

   // Reference model state
   mw_t         mq    [2][$];
   int unsigned ptr_m [2];
   logic [15:0] cnt_m [2];
   logic [31:0] pend  [2][3][$];
   logw_t       lg    [2][$];

   logic [31:0] t4_data [4] = '{32'h300, 32'h320, 32'h301, 32'h321};
   int          t4_src  [4] = '{0, 2, 0, 2};

   always #5 clk = ~clk;

   fifo_in_rr_merge #(
      .N_IN(2)
   ) dut0 (
      .clk         (clk),
      .rst         (rst),
      .data_in     (dat_drv[0][1:0]),
      .data_in_vld (vld_drv[0][1:0]),
      .data_in_rdy (rdy0),
      .data_out    (dout0),
      .data_out_src(src0),
      .data_out_vld(ov0),
      .data_out_rdy(ordy[0]),
      .xfer_cnt    (cnt0)
   );

   fifo_in_rr_merge #(
      .N_IN(3)
   ) dut1 (
      .clk         (clk),
      .rst         (rst),
      .data_in     (dat_drv[1]),
      .data_in_vld (vld_drv[1]),
      .data_in_rdy (rdy1),
      .data_out    (dout1),
      .data_out_src(src1),
      .data_out_vld(ov1),
      .data_out_rdy(ordy[1]),
      .xfer_cnt    (cnt1)
   );

   function automatic int np(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic logic [31:0] o_data(input int k);
      return (k == 0) ? dout0 : dout1;
   endfunction

   function automatic logic [1:0] o_src(input int k);
      return (k == 0) ? {1'b0, src0} : src1;
   endfunction

   function automatic logic o_vld(input int k);
      return (k == 0) ? ov0 : ov1;
   endfunction

   function automatic logic [15:0] o_cnt(input int k);
      return (k == 0) ? cnt0 : cnt1;
   endfunction

   function automatic logic [2:0] o_rdy(input int k);
      return (k == 0) ? {1'b0, rdy0} : rdy1;
   endfunction

   // First requesting port at or after the round-robin pointer, or -1.
   function automatic int grant(input int k);
      for (int i = 0; i < np(k); i++) begin
         int p;
         p = (int'(ptr_m[k]) + i) % np(k);
         if (vld_drv[k][p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [2:0] exp_rdy(input int k);
      logic [2:0] r;
      int g;
      r = '0;
      g = grant(k);
      if (!rst && g >= 0 && mq[k].size() < 2) r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic busy(input int k);
      logic b;
      b = mq[k].size() > 0;
      for (int p = 0; p < 3; p++) begin
         if (pend[k][p].size() > 0) b = 1'b1;
      end
      return b;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   // Model advances on every rising edge from the inputs the DUT sampled.
   initial begin
      forever begin
         @(posedge clk);
         cycle++;
         for (int k = 0; k < 2; k++) begin
            int   g;
            logic inf;
            logic outf;
            g    = grant(k);
            inf  = !rst && g >= 0 && mq[k].size() < 2;
            outf = mq[k].size() > 0 && ordy[k];
            if (rst) begin
               mq[k].delete();
               ptr_m[k] = 0;
               cnt_m[k] = '0;
            end else begin
               if (outf) begin
                  void'(mq[k].pop_front());
                  cnt_m[k] = cnt_m[k] + 16'd1;
               end
               if (inf) begin
                  mq[k].push_back('{src: 2'(g), data: dat_drv[k][g]});
                  ptr_m[k] = (g + 1) % np(k);
                  void'(pend[k][g].pop_front());
               end
            end
         end
      end
   end

   // Every falling edge: outputs and readies against the model, plus a handshake log.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            logic vexp;
            vexp = mq[k].size() > 0;
            chk("data_out_vld", k, 32'(o_vld(k)), 32'(vexp));
            if (vexp) begin
               chk("data_out", k, o_data(k), mq[k][0].data);
               chk("data_out_src", k, 32'(o_src(k)), 32'(mq[k][0].src));
            end
            chk("xfer_cnt", k, 32'(o_cnt(k)), 32'(cnt_m[k]));
            chk("data_in_rdy", k, 32'(o_rdy(k)), 32'(exp_rdy(k)));
            if (o_vld(k) && ordy[k]) begin
               lg[k].push_back('{cyc: cycle, src: o_src(k), data: o_data(k)});
            end
         end
      end
   end

   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < np(k); p++) begin
            if (pend[k][p].size() > 0) begin
               vld_drv[k][p] = 1'b1;
               dat_drv[k][p] = pend[k][p][0];
            end else begin
               vld_drv[k][p] = 1'b0;
               dat_drv[k][p] = '0;
            end
         end
      end
   endtask

   task automatic at_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         at_edge();
         drive();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      drive();
   endtask

   task automatic wait_idle(input int k, input int budget);
      int n = 0;
      while (busy(k) && n < budget) begin
         cyc(1);
         n++;
      end
      chk("drain", k, 32'(busy(k)), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         vld_drv[k] = '0;
         dat_drv[k] = '0;
         ordy[k]    = 1'b1;
         ptr_m[k]   = 0;
         cnt_m[k]   = '0;
      end

      // Reset state
      rst = 1'b1;
      cyc(2);
      @(negedge clk);
      chk("rst_vld", 0, 32'(ov0), 32'd0);
      chk("rst_data", 0, dout0, 32'd0);
      chk("rst_src", 0, 32'(src0), 32'd0);
      chk("rst_cnt", 0, 32'(cnt0), 32'd0);
      chk("rst_vld", 1, 32'(ov1), 32'd0);
      at_edge();
      rst = 1'b0;
      drive();

      // Single port back-to-back
      lg[0].delete();
      for (int i = 0; i < 4; i++) pend[0][0].push_back(32'hA0 + 32'(i));
      drive();
      wait_idle(0, 50);
      chk("t1_count", 0, 32'(lg[0].size()), 32'd4);
      for (int i = 0; i < 4 && i < lg[0].size(); i++) begin
         chk("t1_data", 0, lg[0][i].data, 32'hA0 + 32'(i));
         chk("t1_src", 0, 32'(lg[0][i].src), 32'd0);
         chk("t1_gap", 0, lg[0][i].cyc, lg[0][0].cyc + 32'(i));
      end
      chk("t1_xfer_cnt", 0, 32'(cnt0), 32'd4);

      // Two-port contention
      do_reset();
      lg[0].delete();
      for (int i = 0; i < 4; i++) begin
         pend[0][0].push_back(32'h100 + 32'(i));
         pend[0][1].push_back(32'h200 + 32'(i));
      end
      drive();
      wait_idle(0, 50);
      chk("t2_count", 0, 32'(lg[0].size()), 32'd8);
      for (int i = 0; i < 8 && i < lg[0].size(); i++) begin
         chk("t2_data", 0, lg[0][i].data,
             ((i % 2 == 0) ? 32'h100 : 32'h200) + 32'(i / 2));
         chk("t2_src", 0, 32'(lg[0][i].src), 32'(i % 2));
         chk("t2_gap", 0, lg[0][i].cyc, lg[0][0].cyc + 32'(i));
      end

      // Backpressure with a full skid stage
      do_reset();
      lg[0].delete();
      ordy[0] = 1'b0;
      for (int i = 0; i < 6; i++) pend[0][0].push_back(32'h10 + 32'(i));
      drive();
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         @(negedge clk);
         chk("t3_vld", 0, 32'(ov0), 32'd1);
         chk("t3_hold", 0, dout0, 32'h10);
         if (i > 0) chk("t3_rdy", 0, 32'(rdy0), 32'd0);
      end
      at_edge();
      ordy[0] = 1'b1;
      drive();
      wait_idle(0, 50);
      chk("t3_count", 0, 32'(lg[0].size()), 32'd6);
      for (int i = 0; i < 6 && i < lg[0].size(); i++) begin
         chk("t3_data", 0, lg[0][i].data, 32'h10 + 32'(i));
      end

      // Three ports, port 1 idle: pointer wrap from 2 to 0
      do_reset();
      lg[1].delete();
      pend[1][0].push_back(32'h300);
      pend[1][0].push_back(32'h301);
      pend[1][2].push_back(32'h320);
      pend[1][2].push_back(32'h321);
      drive();
      wait_idle(1, 50);
      chk("t4_count", 1, 32'(lg[1].size()), 32'd4);
      for (int i = 0; i < 4 && i < lg[1].size(); i++) begin
         chk("t4_data", 1, lg[1][i].data, t4_data[i]);
         chk("t4_src", 1, 32'(lg[1][i].src), 32'(t4_src[i]));
         chk("t4_gap", 1, lg[1][i].cyc, lg[1][0].cyc + 32'(i));
      end

      // Reset mid-operation with main and skid occupied
      do_reset();
      for (int i = 0; i < 8; i++) pend[0][0].push_back(32'h50 + 32'(i));
      drive();
      cyc(3);
      ordy[0] = 1'b0;
      cyc(2);
      @(negedge clk);
      chk("t5_full_vld", 0, 32'(ov0), 32'd1);
      chk("t5_full_rdy", 0, 32'(rdy0), 32'd0);
      chk("t5_pre_cnt", 0, 32'(cnt0), 32'd2);
      at_edge();
      rst = 1'b1;
      pend[1][1].push_back(32'h3A0);
      drive();
      @(negedge clk);
      chk("t5_rst_rdy", 0, 32'(rdy0), 32'd0);
      chk("t5_rst_rdy", 1, 32'(rdy1), 32'd0);
      at_edge();
      rst = 1'b0;
      ordy[0] = 1'b1;
      lg[0].delete();
      lg[1].delete();
      drive();
      @(negedge clk);
      chk("t5_post_vld", 0, 32'(ov0), 32'd0);
      chk("t5_post_cnt", 0, 32'(cnt0), 32'd0);
      chk("t5_post_data", 0, dout0, 32'd0);
      chk("t5_post_vld", 1, 32'(ov1), 32'd0);
      wait_idle(0, 50);
      wait_idle(1, 50);
      chk("t5_count", 0, 32'(lg[0].size()), 32'd4);
      for (int i = 0; i < 4 && i < lg[0].size(); i++) begin
         chk("t5_data", 0, lg[0][i].data, 32'h54 + 32'(i));
         chk("t5_src", 0, 32'(lg[0][i].src), 32'd0);
      end
      chk("t5_count", 1, 32'(lg[1].size()), 32'd1);
      if (lg[1].size() > 0) begin
         chk("t5_data", 1, lg[1][0].data, 32'h3A0);
         chk("t5_src", 1, 32'(lg[1][0].src), 32'd1);
      end

      // Transfer counter wrap
      do_reset();
      for (int i = 0; i < 65535; i++) pend[0][0].push_back(32'(i));
      drive();
      wait_idle(0, 70000);
      lg[0].delete();
      chk("t6_cnt_max", 0, 32'(cnt0), 32'h0000FFFF);
      pend[0][0].push_back(32'hBEEF);
      drive();
      wait_idle(0, 20);
      chk("t6_cnt_wrap", 0, 32'(cnt0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
